// File: rtl/ipc_mailbox_pkg.sv
// Package for the IPC mailbox: widths, register selector enum and helpers
// that decode the low address nibble and pack the STATUS / SEM read words.
`include "ipc_mailbox_defines.sv"

package ipc_mailbox_pkg;

  localparam int AW = `BUS_ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;

  typedef enum logic [2:0] {
    REG_DATA,
    REG_STATUS,
    REG_SEM,
    REG_RSVD,
    REG_NONE
  } reg_sel_e;

  // Only the four word-aligned offsets are registers; anything else is a hole.
  function automatic reg_sel_e decode_off(input logic [3:0] off);
    case (off)
      `MBOX_OFF_DATA:   return REG_DATA;
      `MBOX_OFF_STATUS: return REG_STATUS;
      `MBOX_OFF_SEM:    return REG_SEM;
      `MBOX_OFF_RSVD:   return REG_RSVD;
      default:          return REG_NONE;
    endcase
  endfunction

  function automatic logic [DW-1:0] pack_status(input logic       rx_empty,
                                                input logic       tx_full,
                                                input logic       ovf,
                                                input logic [3:0] rx_cnt);
    logic [DW-1:0] w;
    w = '0;
    w[`ST_RX_EMPTY]              = rx_empty;
    w[`ST_TX_FULL]               = tx_full;
    w[`ST_OVF]                   = ovf;
    w[`ST_CNT_MSB:`ST_CNT_LSB]   = rx_cnt;
    return w;
  endfunction

  function automatic logic [DW-1:0] pack_sem(input logic locked,
                                             input logic owner,
                                             input logic requester);
    logic [DW-1:0] w;
    w = '0;
    w[`SEM_LOCKED] = locked;
    w[`SEM_OWNER]  = owner;
    w[`SEM_MINE]   = locked && (owner == requester);
    return w;
  endfunction

endpackage

// File: rtl/ipc_mailbox_if.sv
// Shared-bus interface seen by the mailbox: the granted master drives
// address/data/qualifier and the two active-low grants; the mailbox returns
// read data and its hit (odata mux select).
`include "ipc_mailbox_defines.sv"

interface ipc_mailbox_if;
  import ipc_mailbox_pkg::*;

  logic [AW-1:0] addr;
  logic [DW-1:0] idata;
  logic          rw_;
  logic          bgrt0_;
  logic          bgrt1_;
  logic [DW-1:0] odata;
  logic          hit;

  modport master (output addr, idata, rw_, bgrt0_, bgrt1_,
                  input  odata, hit);

  modport slave  (input  addr, idata, rw_, bgrt0_, bgrt1_,
                  output odata, hit);
endinterface

// File: rtl/ipc_mailbox_defines.sv
// Shared constants for the IPC mailbox: bus widths, active-low enable and
// read/write encodings, register offsets, STATUS/SEM bit positions and the
// default mailbox base. Guarded so every file may include it.
`ifndef IPC_MAILBOX_DEFINES_SV
`define IPC_MAILBOX_DEFINES_SV

`define BUS_ADDR_WIDTH   16
`define DATA_WIDTH       32

`define Enable_          1'b0
`define Disable_         1'b1
`define Read             1'b1
`define Write            1'b0

`define MBOX_BASE_DEF    12'h0F0

`define MBOX_OFF_DATA    4'h0
`define MBOX_OFF_STATUS  4'h4
`define MBOX_OFF_SEM     4'h8
`define MBOX_OFF_RSVD    4'hC

`define ST_RX_EMPTY      0
`define ST_TX_FULL       1
`define ST_OVF           2
`define ST_CNT_LSB       4
`define ST_CNT_MSB       7

`define SEM_LOCKED       0
`define SEM_OWNER        1
`define SEM_MINE         2

`endif

// File: rtl/ipc_mailbox_fifo.sv
// mbox_fifo: small power-of-two FIFO used as one mailbox direction.
// Pushes to a full FIFO and pops from an empty one are ignored here as well,
// so the caller's guards are belt-and-braces. Storage is not reset; only the
// pointers and count are.
`include "ipc_mailbox_defines.sv"

module mbox_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        din_i,
  output logic [DATA_W-1:0]        dout_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q,  count_d;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i  && !empty_o;

  // Next pointers/count; pointer width makes wrap modulo DEPTH implicit.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Control state: cleared immediately by reset.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are meaningless while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ipc_mailbox.sv
// ipc_mailbox: two-CPU mailbox on a shared bus. box0 carries CPU1->CPU0,
// box1 carries CPU0->CPU1; the requester (from the active-low grants) reads
// its own rx box and writes the other one. Reads are purely combinational;
// a write takes effect once per contiguous write-hit phase (first cycle).
// Optional hardware semaphore enabled by defining MBOX_SEM_EN; without it
// the SEM offset reads 0 and ignores writes.
// STATUS reports rx_count in four bits, so DEPTH is expected to be <= 8.
`include "ipc_mailbox_defines.sv"

module ipc_mailbox
  import ipc_mailbox_pkg::*;
#(
  parameter logic [AW-5:0] MBOX_BASE = `MBOX_BASE_DEF,
  parameter int            DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset_,
  ipc_mailbox_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          grant;
  logic          req;
  logic          rx, tx;
  logic          hit;
  reg_sel_e      sel;
  logic          wr_hit;
  logic          wr_hit_q;
  logic          accept;

  logic [1:0]    push, pop;
  logic [1:0]    empty, full;
  logic [DW-1:0] dout [2];
  logic [CW-1:0] cnt  [2];

  logic [1:0]    ovf_q, ovf_d;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] sem_rd;

  // CPU0's grant wins if both are somehow asserted.
  assign grant  = (bus.bgrt0_ == `Enable_) || (bus.bgrt1_ == `Enable_);
  assign req    = (bus.bgrt0_ == `Enable_) ? 1'b0 : 1'b1;
  assign rx     = req;
  assign tx     = ~req;
  assign hit    = grant && (bus.addr[AW-1:4] == MBOX_BASE);
  assign sel    = decode_off(bus.addr[3:0]);
  assign wr_hit = hit && (bus.rw_ == `Write);
  assign accept = wr_hit && !wr_hit_q;

  assign bus.hit   = hit;
  assign bus.odata = rd_data;

  // Remember last cycle's write-hit so held writes act only once.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) wr_hit_q <= 1'b0;
    else         wr_hit_q <= wr_hit;
  end

  // FIFO strobes: DATA write pushes tx, STATUS bit0 pops a non-empty rx.
  always_comb begin
    push = '0;
    pop  = '0;
    if (accept && sel == REG_DATA) push[tx] = 1'b1;
    if (accept && sel == REG_STATUS && bus.idata[0] && !empty[rx]) pop[rx] = 1'b1;
  end

  for (genvar b = 0; b < 2; b++) begin : g_box
    mbox_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DW)
    ) u_fifo (
      .clk     (clk),
      .reset_  (reset_),
      .push_i  (push[b]),
      .pop_i   (pop[b]),
      .din_i   (bus.idata),
      .dout_o  (dout[b]),
      .empty_o (empty[b]),
      .full_o  (full[b]),
      .count_o (cnt[b])
    );
  end

  // Sticky overflow per requester: set on a dropped push, cleared by STATUS bit2.
  always_comb begin
    ovf_d = ovf_q;
    if (accept && sel == REG_DATA && full[tx]) ovf_d[req] = 1'b1;
    if (accept && sel == REG_STATUS && bus.idata[2]) ovf_d[req] = 1'b0;
  end

  // Overflow flags register.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) ovf_q <= '0;
    else         ovf_q <= ovf_d;
  end

`ifdef MBOX_SEM_EN
  logic sem_locked_q, sem_locked_d;
  logic sem_owner_q,  sem_owner_d;

  // Semaphore: acquire only when free, release only by the current owner.
  always_comb begin
    sem_locked_d = sem_locked_q;
    sem_owner_d  = sem_owner_q;
    if (accept && sel == REG_SEM) begin
      if (bus.idata[0] && !sem_locked_q) begin
        sem_locked_d = 1'b1;
        sem_owner_d  = req;
      end else if (!bus.idata[0] && sem_locked_q && sem_owner_q == req) begin
        sem_locked_d = 1'b0;
      end
    end
  end

  // Semaphore state register.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      sem_locked_q <= 1'b0;
      sem_owner_q  <= 1'b0;
    end else begin
      sem_locked_q <= sem_locked_d;
      sem_owner_q  <= sem_owner_d;
    end
  end

  assign sem_rd = pack_sem(sem_locked_q, sem_owner_q, req);
`else
  assign sem_rd = '0;
`endif

  // Side-effect-free read mux; zero whenever the mailbox is not addressed.
  always_comb begin
    rd_data = '0;
    if (hit) begin
      case (sel)
        REG_DATA:   rd_data = empty[rx] ? '0 : dout[rx];
        REG_STATUS: rd_data = pack_status(empty[rx], full[tx], ovf_q[req], 4'(cnt[rx]));
        REG_SEM:    rd_data = sem_rd;
        default:    rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ipc_mailbox.sv
// Self-checking bench for ipc_mailbox: directed scenarios followed by random
// bus traffic, all checked against a queue-based reference model.
module tb_ipc_mailbox;
  import ipc_mailbox_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [15:0] BASE  = 16'h0F00;

  logic clk = 1'b0;
  logic reset_;
  always #5 clk = ~clk;

  ipc_mailbox_if bus ();

  ipc_mailbox #(.MBOX_BASE(12'h0F0), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one queue per mailbox, flags as plain bits.
  logic [31:0] mb0[$];
  logic [31:0] mb1[$];
  bit ovf0, ovf1;
  bit sem_lk, sem_own;
  bit prev_wr;

  function automatic int qsize(bit b);
    return b ? mb1.size() : mb0.size();
  endfunction

  function automatic logic [31:0] qhead(bit b);
    if (qsize(b) == 0) return 32'h0;
    return b ? mb1[0] : mb0[0];
  endfunction

  task automatic model_reset();
    mb0.delete(); mb1.delete();
    ovf0 = 0; ovf1 = 0; sem_lk = 0; sem_own = 0; prev_wr = 0;
  endtask

  function automatic logic [31:0] model_read(bit r, logic [3:0] off);
    logic [31:0] w;
    w = 32'h0;
    case (off)
      4'h0: w = qhead(r);
      4'h4: begin
        w[0]   = (qsize(r) == 0);
        w[1]   = (qsize(!r) == DEPTH);
        w[2]   = r ? ovf1 : ovf0;
        w[7:4] = 4'(qsize(r));
      end
`ifdef MBOX_SEM_EN
      4'h8: begin
        w[0] = sem_lk;
        w[1] = sem_own;
        w[2] = sem_lk && (sem_own == r);
      end
`endif
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  task automatic model_write(bit r, logic [3:0] off, logic [31:0] d);
    case (off)
      4'h0: begin
        if (qsize(!r) < DEPTH) begin
          if (r) mb0.push_back(d); else mb1.push_back(d);
        end else begin
          if (r) ovf1 = 1; else ovf0 = 1;
        end
      end
      4'h4: begin
        if (d[0] && qsize(r) > 0) begin
          if (r) void'(mb1.pop_front()); else void'(mb0.pop_front());
        end
        if (d[2]) begin
          if (r) ovf1 = 0; else ovf0 = 0;
        end
      end
`ifdef MBOX_SEM_EN
      4'h8: begin
        if (d[0] && !sem_lk) begin
          sem_lk = 1; sem_own = r;
        end else if (!d[0] && sem_lk && sem_own == r) begin
          sem_lk = 0;
        end
      end
`endif
      default: ;
    endcase
  endtask

  // g: 0 none, 1 CPU0, 2 CPU1, 3 both grants (CPU0 wins).
  task automatic cycle(input int g, input logic [15:0] a, input logic rw,
                       input logic [31:0] d, output logic [31:0] rd);
    bit exp_hit, r, wr;
    @(negedge clk);
    bus.bgrt0_ = !(g == 1 || g == 3);
    bus.bgrt1_ = !(g == 2 || g == 3);
    bus.addr   = a;
    bus.rw_    = rw;
    bus.idata  = d;
    #1;
    exp_hit = (g != 0) && (a[15:4] == BASE[15:4]);
    r       = (g == 2);
    chk("hit", {31'b0, bus.hit}, {31'b0, exp_hit});
    rd = bus.odata;
    if (!exp_hit)  chk("odata_idle", bus.odata, 32'h0);
    else if (rw)   chk("odata_rd", bus.odata, model_read(r, a[3:0]));
    wr = exp_hit && !rw;
    if (wr && !prev_wr) model_write(r, a[3:0], d);
    prev_wr = wr;
  endtask

  task automatic wr(input int g, input logic [3:0] off, input logic [31:0] d);
    logic [31:0] v;
    cycle(g, BASE | 16'(off), 1'b0, d, v);
  endtask

  task automatic rd_expect(input string tag, input int g, input logic [3:0] off,
                           input logic [31:0] exp);
    logic [31:0] v;
    cycle(g, BASE | 16'(off), 1'b1, 32'h0, v);
    chk(tag, v, exp);
  endtask

  task automatic idle();
    logic [31:0] v;
    cycle(0, 16'h0000, 1'b1, 32'h0, v);
  endtask

  initial begin
    int g;
    logic [15:0] a;
    logic        rw;
    logic [31:0] d;
    logic [31:0] v;
    logic [3:0]  off;

    bus.addr = '0; bus.idata = '0; bus.rw_ = 1'b1;
    bus.bgrt0_ = 1'b1; bus.bgrt1_ = 1'b1;
    reset_ = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hit", {31'b0, bus.hit}, 32'h0);
    chk("rst_odata", bus.odata, 32'h0);
    @(negedge clk);
    reset_ = 1'b1;

    // Held write of three cycles counts once.
    wr(1, 4'h0, 32'h12345678);
    wr(1, 4'h0, 32'h12345678);
    wr(1, 4'h0, 32'h12345678);
    rd_expect("c1_data", 2, 4'h0, 32'h12345678);
    rd_expect("c1_status_one", 2, 4'h4, 32'h10);
    wr(2, 4'h4, 32'h1);
    rd_expect("c1_status_drained", 2, 4'h4, 32'h1);

    // Overflow on the fifth push.
    for (int i = 1; i <= 5; i++) begin
      wr(1, 4'h0, 32'(i));
      idle();
    end
    rd_expect("c0_status_ovf", 1, 4'h4, 32'h7);
    rd_expect("c1_status_four", 2, 4'h4, 32'h40);
    for (int i = 1; i <= 4; i++) begin
      rd_expect("c1_fifo_order", 2, 4'h0, 32'(i));
      wr(2, 4'h4, 32'h1);
    end
    rd_expect("c1_status_empty", 2, 4'h4, 32'h1);
    rd_expect("c1_data_empty", 2, 4'h0, 32'h0);

    // Clear overflow, pop on empty rx.
    wr(1, 4'h4, 32'h4);
    rd_expect("c0_ovf_clear", 1, 4'h4, 32'h1);
    wr(2, 4'h4, 32'h1);
    rd_expect("c1_pop_empty", 2, 4'h4, 32'h1);

    // Reserved offset, foreign address, dual grant.
    wr(1, 4'hC, 32'hFFFFFFFF);
    rd_expect("rsvd_read", 1, 4'hC, 32'h0);
    cycle(1, 16'h1000, 1'b1, 32'h0, v);
    chk("miss_odata", v, 32'h0);
    wr(3, 4'h0, 32'hCAFE0001);
    rd_expect("dual_grant_to_c1", 2, 4'h0, 32'hCAFE0001);
    wr(2, 4'h4, 32'h1);

`ifdef MBOX_SEM_EN
    wr(1, 4'h8, 32'h1);
    rd_expect("sem_c0_acq", 1, 4'h8, 32'h5);
    wr(2, 4'h8, 32'h1);
    rd_expect("sem_c1_blocked", 2, 4'h8, 32'h1);
    wr(2, 4'h8, 32'h0);
    rd_expect("sem_c1_norel", 2, 4'h8, 32'h1);
    wr(1, 4'h8, 32'h0);
    rd_expect("sem_c0_rel", 1, 4'h8, 32'h0);
`else
    wr(1, 4'h8, 32'h1);
    rd_expect("sem_absent", 1, 4'h8, 32'h0);
`endif

    // Asynchronous reset with two entries queued.
    wr(1, 4'h0, 32'hA1);
    idle();
    wr(1, 4'h0, 32'hA2);
    rd_expect("pre_rst_status", 2, 4'h4, 32'h20);
    @(posedge clk);
    #2;
    reset_ = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_status", bus.odata, 32'h1);
    @(negedge clk);
    reset_ = 1'b1;
    wr(1, 4'h0, 32'hA5);
    rd_expect("post_rst_status", 2, 4'h4, 32'h10);
    rd_expect("post_rst_data", 2, 4'h0, 32'hA5);

    // Random traffic; about a third of cycles repeat the previous beat.
    g = 0; a = '0; rw = 1'b1; d = '0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) >= 30) begin
        g = $urandom_range(0, 3);
        if ($urandom_range(0, 99) < 88) begin
          case ($urandom_range(0, 4))
            0: off = 4'h0;
            1: off = 4'h4;
            2: off = 4'h8;
            3: off = 4'hC;
            default: off = 4'($urandom_range(0, 15));
          endcase
          a = BASE | 16'(off);
        end else begin
          a = 16'($urandom);
        end
        rw = 1'($urandom_range(0, 1));
        d  = (a[3:0] == 4'h0) ? $urandom : 32'($urandom_range(0, 7));
      end
      cycle(g, a, rw, d, v);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
